// File: rtl/iomem_vga_bridge_if.sv
// picosoc iomem bus bundle between the CPU and the VGA bridge.
// The master drives requests; the slave answers with ready/rdata.
interface iomem_vga_bridge_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

// File: rtl/iomem_vga_bridge.sv
// Queues CPU writes to VGA video memory and drains them on vid_grant.
// CPU reads return the write FIFO status word.
module iomem_vga_bridge #(
   parameter int         ADDR_W = 13,
   parameter int         DEPTH  = 8,
   parameter logic [7:0] BASE   = 8'h04
) (
   input  logic                   clk,
   input  logic                   resetn,
   iomem_vga_bridge_if.slave      bus,
   input  logic                   vid_grant,
   output logic [ADDR_W-1:0]      vid_addr,
   output logic [31:0]            vid_wdata,
   output logic [3:0]             vid_wren,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        strb;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          sel;
   logic          is_wr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          done;
   logic [31:0]   status;

   // Full is judged on the level at cycle start, so a same-cycle
   // pop never opens a slot for a same-cycle push.
   always_comb begin
      sel   = bus.iomem_valid && !bus.iomem_ready &&
              (bus.iomem_addr[31:24] == BASE);
      is_wr = |bus.iomem_wstrb;
      full  = (fifo_level == LW'(DEPTH));
      empty = (fifo_level == '0);
      push  = sel && is_wr && !full;
      pop   = vid_grant && !empty;
      done  = sel && (!is_wr || !full);
      head  = mem[rptr];
      status = {14'd0, full, empty, 16'(fifo_level)};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= '{addr: bus.iomem_addr[ADDR_W+1:2],
                        data: bus.iomem_wdata,
                        strb: bus.iomem_wstrb};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.iomem_ready <= 1'b0;
         bus.iomem_rdata <= '0;
      end else begin
         bus.iomem_ready <= done;
         if (sel && !is_wr) bus.iomem_rdata <= status;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vid_addr  <= '0;
         vid_wdata <= '0;
         vid_wren  <= '0;
      end else begin
         vid_wren <= pop ? head.strb : 4'd0;
         if (pop) begin
            vid_addr  <= head.addr;
            vid_wdata <= head.data;
         end
      end
   end
endmodule

// File: tb/tb_iomem_vga_bridge.sv
// Bench for iomem_vga_bridge: directed plan plus random traffic,
// checked against a queue model of the write FIFO.
module tb_iomem_vga_bridge;
   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        vid_grant = 1'b0;
   logic [12:0] vid_addr;
   logic [31:0] vid_wdata;
   logic [3:0]  vid_wren;
   logic [3:0]  fifo_level;

   iomem_vga_bridge_if bus ();

   iomem_vga_bridge #(
      .ADDR_W(13), .DEPTH(8), .BASE(8'h04)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .vid_grant (vid_grant),
      .vid_addr  (vid_addr),
      .vid_wdata (vid_wdata),
      .vid_wren  (vid_wren),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [48:0] q [$];
   logic [48:0] mon_e;
   int          lvl_at_neg = 0;
   int          max_lvl = 0;
   int          wren_cnt = 0;
   logic [3:0]  last_wren = 4'd0;
   logic        rand_grant = 1'b0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat(input int l);
      logic [31:0] r;
      r = 32'(l);
      if (l == 8) r = r | 32'h0002_0000;
      if (l == 0) r = r | 32'h0001_0000;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!resetn) begin
         q.delete();
         check("rst_wren", 32'(vid_wren), 0);
         check("rst_lvl", 32'(fifo_level), 0);
      end else begin
         if (vid_wren != 4'd0) begin
            wren_cnt++;
            last_wren = vid_wren;
            if (q.size() == 0) begin
               check("spurious_wren", 32'(vid_wren), 0);
            end else begin
               mon_e = q.pop_front();
               check("vid_addr", 32'(vid_addr), 32'(mon_e[48:36]));
               check("vid_wdata", vid_wdata, mon_e[35:4]);
               check("vid_wren", 32'(vid_wren), 32'(mon_e[3:0]));
            end
         end
         check("level", 32'(fifo_level), 32'(q.size()));
         lvl_at_neg = q.size();
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
   end

   always @(negedge clk) begin
      if (rand_grant) vid_grant = ($urandom_range(0, 3) != 0);
   end

   task automatic xfer(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input int budget,
                       output logic got,
                       output logic [31:0] rd,
                       output int cyc);
      logic [31:0] av;
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = a;
      bus.iomem_wdata = d;
      bus.iomem_wstrb = s;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.iomem_ready === 1'b1) got = 1'b1;
      end
      rd = bus.iomem_rdata;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'd0;
      av = a;
      if (got && s != 4'd0 && av[31:24] == 8'h04)
         q.push_back({av[14:2], d, s});
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s);
      logic got;
      logic [31:0] rd;
      int cyc;
      xfer(a, d, s, 300, got, rd, cyc);
      check("wr_done", 32'(got), 1);
   endtask

   task automatic rd_stat(output logic [31:0] rd);
      logic got;
      int cyc;
      xfer(32'h0400_0000, 32'd0, 4'd0, 10, got, rd, cyc);
      check("rd_done", 32'(got), 1);
      check("rd_stat", rd, stat(lvl_at_neg));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || fifo_level != 4'd0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain", 32'(q.size()), 0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        got;
      int          cyc;
      int          n;
      int          w0;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'd0;
      bus.iomem_addr  = 32'd0;
      bus.iomem_wdata = 32'd0;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.iomem_ready), 0);
      check("rst_rdata", bus.iomem_rdata, 0);
      check("rst_vaddr", 32'(vid_addr), 0);
      check("rst_vdata", vid_wdata, 0);
      @(posedge clk);
      #2 resetn = 1'b1;

      // Single write, status, then drain it.
      wr(32'h0400_0010, 32'hDEAD_BEEF, 4'hF);
      @(posedge clk);
      #1 check("ready_pulse", 32'(bus.iomem_ready), 0);
      rd_stat(rd);
      check("stat_one", rd, 32'h0000_0001);
      @(negedge clk);
      vid_grant = 1'b1;
      n = 0;
      while (vid_wren == 4'd0 && n < 5) begin
         @(posedge clk);
         #1 n++;
      end
      check("t1_addr", 32'(vid_addr), 4);
      check("t1_data", vid_wdata, 32'hDEAD_BEEF);
      check("t1_wren", 32'(vid_wren), 32'hF);
      @(posedge clk);
      #1 check("t1_wren_off", 32'(vid_wren), 0);
      drain();

      // Fill to full, stall the 9th, release with one grant.
      @(negedge clk);
      vid_grant = 1'b0;
      for (int i = 0; i < 8; i++)
         wr(32'h0400_0100 + 32'(i * 4), $urandom, 4'hF);
      rd_stat(rd);
      check("stat_full", rd, 32'h0002_0008);
      fork
         xfer(32'h0400_0200, 32'h1234_5678, 4'hF, 20, got, rd, cyc);
         begin
            repeat (6) @(negedge clk);
            vid_grant = 1'b1;
            @(negedge clk);
            vid_grant = 1'b0;
         end
      join
      check("stall_done", 32'(got), 1);
      check("stall_cyc", 32'(cyc), 7);
      vid_grant = 1'b1;
      drain();

      // Streaming writes with grant held high.
      max_lvl = 0;
      w0 = wren_cnt;
      for (int i = 0; i < 16; i++)
         wr(32'h0400_0000 + 32'(i * 4), 32'(i), 4'hF);
      drain();
      check("max_lvl", 32'(max_lvl <= 2), 1);
      check("stream_cnt", 32'(wren_cnt - w0), 16);

      // Byte-lane write.
      wr(32'h0400_0040, 32'h00AB_0000, 4'b0100);
      drain();
      check("byte_wren", 32'(last_wren), 32'b0100);

      // Out-of-window accesses are ignored.
      @(negedge clk);
      vid_grant = 1'b0;
      wr(32'h0400_0080, 32'hCAFE_F00D, 4'hF);
      xfer(32'h0300_0000, 32'h5555_AAAA, 4'hF, 6, got, rd, cyc);
      check("nosel_wr", 32'(got), 0);
      xfer(32'h0300_0000, 32'd0, 4'd0, 6, got, rd, cyc);
      check("nosel_rd", 32'(got), 0);
      check("nosel_lvl", 32'(fifo_level), 1);
      vid_grant = 1'b1;
      drain();

      // Random traffic against random grant.
      rand_grant = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rd_stat(rd);
         end else begin
            wr({8'h04, 24'($urandom)}, $urandom,
               4'($urandom_range(1, 15)));
         end
      end
      rand_grant = 1'b0;
      @(negedge clk);
      vid_grant = 1'b1;
      drain();

      // Asynchronous reset with entries queued.
      vid_grant = 1'b0;
      for (int i = 0; i < 5; i++)
         wr(32'h0400_0300 + 32'(i * 4), $urandom, 4'hF);
      check("pre_rst_lvl", 32'(fifo_level), 5);
      @(negedge clk);
      vid_grant = 1'b1;
      @(posedge clk);
      #1 check("pre_rst_wren", 32'(vid_wren != 4'd0), 1);
      #2 resetn = 1'b0;
      #1 check("arst_wren", 32'(vid_wren), 0);
      check("arst_lvl", 32'(fifo_level), 0);
      @(posedge clk);
      #2 resetn = 1'b1;
      w0 = wren_cnt;
      repeat (20) @(negedge clk);
      check("post_rst_cnt", 32'(wren_cnt - w0), 0);
      check("post_rst_lvl", 32'(fifo_level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/iomem_vga_bridge.md
Name: iomem_vga_bridge

Overview:
- Sits between the picosoc iomem bus and the VGA console's video-memory write port; occupies iomem byte-address window 0x04xx_xxxx.
- Accepts CPU writes into a small FIFO so the CPU is not stalled by video timing.
- Drains queued writes to video memory only in cycles where the video side grants access.
- Answers CPU reads with a FIFO status word.

Parameters:
- ADDR_W, 13, word-address width presented to video memory; taken from iomem_addr[ADDR_W+1:2].
- DEPTH, 8, FIFO entries; power of two, 2..64.
- BASE, 8'h04, required value of iomem_addr[31:24] for selection.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  one-cycle completion pulse (registered).
- iomem_wstrb  in  4  byte strobes; 0 = read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data, valid while iomem_ready=1.
- vid_grant  in  1  video memory may be written this cycle.
- vid_addr  out  ADDR_W  video word address.
- vid_wdata  out  32  video write data.
- vid_wren  out  4  per-byte write enable; 0 = idle.
- fifo_level  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Decided: one clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values: iomem_ready=0, iomem_rdata=0, vid_wren=0, vid_addr=0, vid_wdata=0, fifo_level=0, FIFO pointers=0.
- Reset asserted mid-operation flushes all queued entries; nothing is written afterwards.
- sel = iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE.
- Write accept: sel && wstrb!=0 && level<DEPTH, with level sampled at cycle start.
  - Pushes {addr[ADDR_W+1:2], wdata, wstrb}.
  - iomem_ready=1 on the next cycle for exactly one cycle.
- Write stall: sel && wstrb!=0 && level==DEPTH.
  - No push; iomem_ready held 0.
  - Accept occurs on the first cycle level<DEPTH. A pop in the same cycle does not free a slot for a same-cycle push.
- Read: sel && wstrb==0 always completes; iomem_ready=1 next cycle.
  - iomem_rdata[15:0] = level (zero-extended).
  - iomem_rdata[16] = empty.
  - iomem_rdata[17] = full.
  - iomem_rdata[31:18] = 0.
  - Reads do not alter the FIFO.
- Non-selected cycles: iomem_ready=0; iomem_rdata holds its last value.
- Drain: in any cycle with vid_grant=1 && level>0, pop the head.
  - vid_addr/vid_wdata/vid_wren take the popped entry on the next cycle.
  - vid_wren is nonzero for exactly that one cycle, then returns to 0.
  - vid_addr/vid_wdata hold their last values.
  - At most one pop per cycle.
  - vid_grant with level==0: no pop, vid_wren=0.
- Simultaneous push and pop: both occur; level unchanged; FIFO order strictly preserved.
- Pointers wrap modulo DEPTH; level is DEPTH exactly when full.
- Latency: an accepted write reaches vid_wren no earlier than 2 cycles after the accept cycle, given vid_grant=1 continuously.

Test Plan:
- Reset, then one write addr 0x0400_0010, data 0xDEADBEEF, wstrb 4'b1111, vid_grant=0 → iomem_ready pulses once; status read gives rdata=0x0000_0001. Raise vid_grant → one cycle of vid_addr=4, vid_wdata=0xDEADBEEF, vid_wren=4'hF.
- vid_grant=0; 9 back-to-back writes → first 8 complete; status read before the 9th shows 0x0002_0008; 9th stalls with iomem_ready=0. Single vid_grant pulse → 9th completes the following cycle.
- vid_grant=1 with continuous writes of 0..15 to word addresses 0..15 → vid_wren pulses in order; vid_wdata sequence 0..15; level never exceeds 2.
- Byte write wstrb 4'b0100, data 0x00AB_0000 → vid_wren=4'b0100 on drain.
- Access addr 0x0300_0000 → iomem_ready stays 0; FIFO unchanged.
- Fill 5 entries, assert resetn=0 asynchronously mid-cycle → vid_wren=0 immediately and level=0. After release, vid_grant=1 produces no writes.
